// File: rtl/uart_cmd_decoder.sv
// uart_cmd_decoder
// Turns bytes received from uart_rx into single-cycle control pulses for the
// counter datapath (run/stop, clear, mode, error). Every accepted byte is
// also queued in a small FIFO and echoed back through the uart_tx
// start/busy handshake, one byte in flight at a time.
module uart_cmd_decoder #(
  parameter logic [7:0] CMD_RUN      = 8'h72,
  parameter logic [7:0] CMD_CLEAR    = 8'h63,
  parameter logic [7:0] CMD_MODE     = 8'h6D,
  parameter int         ECHO_EN      = 1,
  parameter int         FIFO_DEPTH   = 4,
  parameter int         BUSY_TIMEOUT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  input  logic       tx_busy,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic       o_run_stop,
  output logic       o_clear,
  output logic       o_mode,
  output logic       o_cmd_err,
  output logic       o_overflow
);

  localparam int NUM_CMDS = 3;
  // FIFO_DEPTH is a power of two (>= 2), so pointers wrap for free.
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  // One extra bit so "full" (count == FIFO_DEPTH) is representable.
  localparam int CNT_W = PTR_W + 1;
  // Wide enough to count 0 .. BUSY_TIMEOUT-1.
  localparam int TMR_W = $clog2(BUSY_TIMEOUT + 1);

  // Command table: index 0 = run/stop, 1 = clear, 2 = mode.
  localparam logic [NUM_CMDS-1:0][7:0] CMD_TABLE = {CMD_MODE, CMD_CLEAR, CMD_RUN};

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } echo_state_t;

  logic [NUM_CMDS-1:0] cmd_hit;
  logic [NUM_CMDS-1:0] cmd_pulse_reg;
  logic                cmd_err_reg;

  genvar gi;

  // Exact 8-bit comparison against each command byte; no case folding.
  generate
    for (gi = 0; gi < NUM_CMDS; gi++) begin : g_cmd_match
      assign cmd_hit[gi] = (rx_data == CMD_TABLE[gi]);
    end
  endgenerate

  // Decode register: exactly one pulse, one cycle after each rx_done strobe.
  // Independent of FIFO state, so dropped bytes are still decoded.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_pulse_reg <= '0;
      cmd_err_reg   <= 1'b0;
    end else begin
      cmd_pulse_reg <= rx_done ? cmd_hit : '0;
      cmd_err_reg   <= rx_done && (cmd_hit == '0);
    end
  end

  assign o_run_stop = cmd_pulse_reg[0];
  assign o_clear    = cmd_pulse_reg[1];
  assign o_mode     = cmd_pulse_reg[2];
  assign o_cmd_err  = cmd_err_reg;

  generate
    if (ECHO_EN != 0) begin : g_echo
      logic [7:0]       fifo_mem [FIFO_DEPTH];
      logic [PTR_W-1:0] wr_ptr_reg;
      logic [PTR_W-1:0] rd_ptr_reg;
      logic [CNT_W-1:0] count_reg;
      logic             overflow_reg;
      logic [7:0]       tx_data_reg;
      logic [TMR_W-1:0] timer_reg;
      echo_state_t      state_reg;
      echo_state_t      state_next;
      logic             fifo_full;
      logic             fifo_empty;
      logic             push;
      logic             pop;
      logic             drop;
      logic             launch;
      logic             busy_timed_out;

      assign fifo_full  = (count_reg == CNT_W'(FIFO_DEPTH));
      assign fifo_empty = (count_reg == '0);
      // The head leaves the FIFO in the cycle its tx_start is issued.
      assign pop        = (state_reg == START);
      // A pop in the same cycle frees a slot, so a full FIFO still accepts.
      assign push       = rx_done && (!fifo_full || pop);
      assign drop       = rx_done && fifo_full && !pop;
      assign launch     = (state_reg == IDLE) && (state_next == START);
      assign busy_timed_out = (timer_reg == TMR_W'(BUSY_TIMEOUT - 1));

      // Echo byte storage: written on accepted pushes only.
      always_ff @(posedge clk) begin
        if (push) begin
          fifo_mem[wr_ptr_reg] <= rx_data;
        end
      end

      // FIFO pointers, occupancy and the sticky overflow flag.
      always_ff @(posedge clk) begin
        if (rst) begin
          wr_ptr_reg   <= '0;
          rd_ptr_reg   <= '0;
          count_reg    <= '0;
          overflow_reg <= 1'b0;
        end else begin
          if (push) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
          end
          if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
          end
          case ({push, pop})
            2'b10:   count_reg <= count_reg + CNT_W'(1);
            2'b01:   count_reg <= count_reg - CNT_W'(1);
            default: count_reg <= count_reg;
          endcase
          if (drop) begin
            overflow_reg <= 1'b1;
          end
        end
      end

      // Echo FSM state register.
      always_ff @(posedge clk) begin
        if (rst) begin
          state_reg <= IDLE;
        end else begin
          state_reg <= state_next;
        end
      end

      // Echo FSM next-state logic: launch, wait for busy to rise, wait for it to fall.
      always_comb begin
        state_next = state_reg;
        case (state_reg)
          IDLE: begin
            if (!fifo_empty && !tx_busy) begin
              state_next = START;
            end
          end
          START: begin
            state_next = WAIT_BUSY;
          end
          WAIT_BUSY: begin
            if (tx_busy) begin
              state_next = WAIT_DONE;
            end else if (busy_timed_out) begin
              // The transmitter never acknowledged; the byte counts as sent.
              state_next = IDLE;
            end
          end
          WAIT_DONE: begin
            if (!tx_busy) begin
              state_next = IDLE;
            end
          end
          default: begin
            state_next = IDLE;
          end
        endcase
      end

      // Latch the FIFO head on entry to START so tx_data is valid alongside
      // tx_start and stays put until the next launch; time the busy wait.
      always_ff @(posedge clk) begin
        if (rst) begin
          tx_data_reg <= 8'h00;
          timer_reg   <= '0;
        end else begin
          if (launch) begin
            tx_data_reg <= fifo_mem[rd_ptr_reg];
          end
          if (state_reg == WAIT_BUSY) begin
            timer_reg <= timer_reg + TMR_W'(1);
          end else begin
            timer_reg <= '0;
          end
        end
      end

      // Gating with rst keeps a start strobe from escaping in a reset cycle.
      assign tx_start   = (state_reg == START) && !rst;
      assign tx_data    = tx_data_reg;
      assign o_overflow = overflow_reg;
    end else begin : g_no_echo
      logic unused_tx_busy;
      assign unused_tx_busy = tx_busy;
      assign tx_start       = 1'b0;
      assign tx_data        = 8'h00;
      assign o_overflow     = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Testbench for uart_cmd_decoder: an echo-enabled instance and an
// echo-disabled instance share the same stimulus. A queue-based model of the
// echo FIFO plus a byte-to-pulse table predict outputs every cycle; directed
// tests pin the model with hand-computed literals.
`timescale 1ns/1ps
module tb_uart_cmd_decoder;

  localparam int DEPTH     = 4;
  localparam int BUSY_HIGH = 10;

  logic       clk        = 1'b0;
  logic       rst        = 1'b1;
  logic [7:0] rx_data    = 8'h00;
  logic       rx_done    = 1'b0;
  logic       tx_busy;
  logic       busy_force = 1'b0;
  logic       busy_mute  = 1'b0;
  int         busy_left  = 0;

  logic       tx_start, o_run_stop, o_clear, o_mode, o_cmd_err, o_overflow;
  logic [7:0] tx_data;
  logic       tx_start_b, o_run_stop_b, o_clear_b, o_mode_b, o_cmd_err_b, o_overflow_b;
  logic [7:0] tx_data_b;

  int n_tests = 0;
  int n_fail  = 0;
  int cycle   = 0;

  logic [7:0] echo_q[$];     // bytes accepted but not yet launched
  logic [7:0] tx_log[$];     // every byte seen with tx_start
  int         start_cyc[$];  // cycle number of every tx_start
  logic [7:0] last_tx = 8'h00;

  assign tx_busy = busy_force || (busy_left > 0);

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  uart_cmd_decoder #(.ECHO_EN(1), .FIFO_DEPTH(DEPTH), .BUSY_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_done(rx_done), .tx_busy(tx_busy),
    .tx_start(tx_start), .tx_data(tx_data), .o_run_stop(o_run_stop), .o_clear(o_clear),
    .o_mode(o_mode), .o_cmd_err(o_cmd_err), .o_overflow(o_overflow)
  );

  uart_cmd_decoder #(.ECHO_EN(0), .FIFO_DEPTH(DEPTH), .BUSY_TIMEOUT(4)) dut_noecho (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_done(rx_done), .tx_busy(tx_busy),
    .tx_start(tx_start_b), .tx_data(tx_data_b), .o_run_stop(o_run_stop_b), .o_clear(o_clear_b),
    .o_mode(o_mode_b), .o_cmd_err(o_cmd_err_b), .o_overflow(o_overflow_b)
  );

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // {err, mode, clear, run} expected one cycle after a byte arrives.
  function automatic logic [3:0] expect_pulses(logic valid, logic [7:0] b);
    if (!valid) return 4'b0000;
    case (b)
      8'h72:   return 4'b0001;
      8'h63:   return 4'b0010;
      8'h6D:   return 4'b0100;
      default: return 4'b1000;
    endcase
  endfunction

  // Compare process: checks the current cycle, then advances the model.
  initial begin : compare_proc
    logic [3:0] exp_pulse;
    logic       exp_ovf;
    logic       seen_rst;
    int         occ;
    exp_pulse = 4'b0000;
    exp_ovf   = 1'b0;
    seen_rst  = 1'b0;
    forever begin
      @(negedge clk);
      if (seen_rst) begin
        check("run_stop",    o_run_stop,   exp_pulse[0]);
        check("clear",       o_clear,      exp_pulse[1]);
        check("mode",        o_mode,       exp_pulse[2]);
        check("cmd_err",     o_cmd_err,    exp_pulse[3]);
        check("run_stop_ne", o_run_stop_b, exp_pulse[0]);
        check("clear_ne",    o_clear_b,    exp_pulse[1]);
        check("mode_ne",     o_mode_b,     exp_pulse[2]);
        check("cmd_err_ne",  o_cmd_err_b,  exp_pulse[3]);
        check("overflow",    o_overflow,   exp_ovf);
        check("overflow_ne", o_overflow_b, 1'b0);
        check("tx_start_ne", tx_start_b,   1'b0);
        check("tx_data_ne",  tx_data_b,    8'h00);
        if (rst) check("tx_start_in_rst", tx_start, 1'b0);
        if (tx_start) begin
          check("start_nonempty", (echo_q.size() != 0), 1'b1);
          if (echo_q.size() != 0) check("echo_byte", tx_data, echo_q[0]);
        end else if (busy_left > 0 && !rst) begin
          check("tx_data_hold", tx_data, last_tx);
        end
      end
      if (rst) begin
        echo_q.delete();
        exp_ovf   = 1'b0;
        exp_pulse = 4'b0000;
        busy_left = 0;
        seen_rst  = 1'b1;
      end else begin
        occ = echo_q.size();
        if (tx_start) begin
          last_tx = tx_data;
          tx_log.push_back(tx_data);
          start_cyc.push_back(cycle);
          if (occ > 0) void'(echo_q.pop_front());
          if (!busy_mute) busy_left = BUSY_HIGH;
        end else if (busy_left > 0) begin
          busy_left--;
        end
        if (rx_done) begin
          if (occ < DEPTH || tx_start) echo_q.push_back(rx_data);
          else exp_ovf = 1'b1;
        end
        exp_pulse = expect_pulses(rx_done, rx_data);
      end
    end
  end

  task automatic tick(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
    rx_data = 8'h00;
  endtask

  task automatic wait_idle(string tag);
    int k;
    k = 0;
    while ((echo_q.size() != 0 || busy_left != 0) && k < 400) begin
      tick();
      k++;
    end
    check(tag, (k < 400), 1'b1);
    tick(4);
  endtask

  task automatic check_log(string tag, int idx, logic [7:0] exp);
    logic [7:0] got;
    got = 8'hxx;
    if (idx < tx_log.size()) got = tx_log[idx];
    check(tag, {24'h0, got}, {24'h0, exp});
  endtask

  initial begin : watchdog
    #200us;
    $display("FAIL watchdog: still running at %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int base;
    int push_cyc;

    // Reset state
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    @(negedge clk);
    check("rst_tx_start", tx_start, 1'b0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_overflow", o_overflow, 1'b0);
    check("rst_run_stop", o_run_stop, 1'b0);
    tick();

    // 'r': run/stop pulse and one echo
    base = tx_log.size();
    send(8'h72);
    @(negedge clk);
    check("r_run_stop", o_run_stop, 1'b1);
    check("r_clear", o_clear, 1'b0);
    tick();
    wait_idle("r_idle");
    check("r_echo_count", tx_log.size(), base + 1);
    check_log("r_echo", base, 8'h72);

    // 'c', 'm', 'A' spaced 20 cycles apart
    base = tx_log.size();
    send(8'h63);
    @(negedge clk);
    check("c_clear", o_clear, 1'b1);
    tick(19);
    send(8'h6D);
    @(negedge clk);
    check("m_mode", o_mode, 1'b1);
    tick(19);
    send(8'h41);
    @(negedge clk);
    check("A_cmd_err", o_cmd_err, 1'b1);
    tick();
    wait_idle("cma_idle");
    check("cma_echo_count", tx_log.size(), base + 3);
    check_log("cma_echo0", base, 8'h63);
    check_log("cma_echo1", base + 1, 8'h6D);
    check_log("cma_echo2", base + 2, 8'h41);
    check("cma_overflow", o_overflow, 1'b0);

    // Full FIFO: push lands in the same cycle as the START pop
    base = tx_log.size();
    busy_force = 1'b1;
    send(8'h11);
    send(8'h22);
    send(8'h33);
    send(8'h44);
    tick(2);
    busy_force = 1'b0;
    tick();
    push_cyc = cycle;
    send(8'h55);
    wait_idle("full_pop_idle");
    check("full_pop_start_cycle", start_cyc[base], push_cyc);
    check("full_pop_echo_count", tx_log.size(), base + 5);
    check_log("full_pop_echo0", base, 8'h11);
    check_log("full_pop_echo3", base + 3, 8'h44);
    check_log("full_pop_echo4", base + 4, 8'h55);
    check("full_pop_overflow", o_overflow, 1'b0);

    // tx_busy never rises: 4-cycle timeout then next byte launches
    base = tx_log.size();
    busy_mute = 1'b1;
    send(8'hA1);
    send(8'hA2);
    wait_idle("timeout_idle");
    tick(8);
    busy_mute = 1'b0;
    check("timeout_echo_count", tx_log.size(), base + 2);
    check_log("timeout_echo0", base, 8'hA1);
    check_log("timeout_echo1", base + 1, 8'hA2);
    check("timeout_gap", start_cyc[base + 1] - start_cyc[base], 6);

    // Overflow: hold tx_busy, send 01..06
    base = tx_log.size();
    busy_force = 1'b1;
    for (int b = 1; b <= 6; b++) begin
      send(8'(b));
      @(negedge clk);
      if (b <= 4) check("ovf_clear_before_5", o_overflow, 1'b0);
      else check("ovf_set_after_5", o_overflow, 1'b1);
      if (b == 6) check("ovf_byte6_cmd_err", o_cmd_err, 1'b1);
      tick();
    end
    busy_force = 1'b0;
    wait_idle("ovf_idle");
    check("ovf_echo_count", tx_log.size(), base + 4);
    for (int i = 0; i < 4; i++) check_log("ovf_echo", base + i, 8'(i + 1));
    check("ovf_sticky", o_overflow, 1'b1);

    // Reset in WAIT_DONE with two bytes queued
    base = tx_log.size();
    send(8'h31);
    send(8'h32);
    send(8'h33);
    tick(3);
    check("rst_mid_first_echo", tx_log.size(), base + 1);
    check("rst_mid_queued", echo_q.size(), 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_tx_start", tx_start, 1'b0);
    check("rst_mid_tx_data", tx_data, 8'h00);
    check("rst_mid_overflow", o_overflow, 1'b0);
    check("rst_mid_pulses", {o_run_stop, o_clear, o_mode, o_cmd_err}, 4'b0000);
    check("rst_mid_tx_data_ne", tx_data_b, 8'h00);
    tick(40);
    check("rst_mid_no_more_echo", tx_log.size(), base + 1);
    check_log("rst_mid_echo0", base, 8'h31);

    // Decode still works on both instances after reset
    send(8'h72);
    @(negedge clk);
    check("post_rst_run_stop", o_run_stop, 1'b1);
    check("post_rst_run_stop_ne", o_run_stop_b, 1'b1);
    tick();
    wait_idle("post_rst_idle");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
